// File: rtl/uart_tx_feeder_if.sv
// Host write port of the UART transmit feeder: valid/ready handshake carrying 9-bit words.
interface uart_tx_feeder_if;
  logic       wr_valid;
  logic [8:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_feeder.sv
// Buffered UART transmit front end: a show-ahead FIFO plus a level-held start request
// that waits for the driver's busy acknowledge before popping the head word.
module uart_tx_feeder #(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_tx_feeder_if.slave              wr_if,
  input  logic                         flush,
  output logic                         uart_start,
  output logic [8:0]                   uart_data,
  input  logic                         uart_busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         fifo_empty,
  output logic                         frame_done,
  output logic                         timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            uart_start_q, uart_start_d;
  logic            frame_done_q, frame_done_d;
  logic            timeout_err_q, timeout_err_d;
  logic [8:0]      mem [DEPTH];

  logic push, pop, expire, in_req;

  assign in_req = (state_q == S_REQ);
  // flush wins over both the host write and the acknowledge-driven pop
  assign push   = wr_if.wr_valid && wr_if.wr_ready && !flush;
  assign pop    = in_req && uart_busy && !flush;
  assign expire = in_req && !uart_busy && !flush && (timer_q == TW'(START_TIMEOUT - 1));

  assign wr_if.wr_ready = (count_q != CW'(DEPTH));
  assign uart_data      = mem[rd_ptr_q];
  assign fifo_count     = count_q;
  assign fifo_empty     = (count_q == '0);
  assign uart_start     = uart_start_q;
  assign frame_done     = frame_done_q;
  assign timeout_err    = timeout_err_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      uart_start_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      uart_start_q  <= uart_start_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_if.wr_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // Next-state logic; the timer only runs while a request is outstanding
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      S_IDLE: if (!fifo_empty && !uart_busy && !flush) state_d = S_REQ;
      S_REQ: begin
        if (pop)                 state_d = S_WAIT;
        else if (flush || expire) state_d = S_IDLE;
        else                     timer_d = timer_q + TW'(1);
      end
      S_WAIT: if (!uart_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    uart_start_d  = (state_d == S_REQ);
    frame_done_d  = (state_q == S_WAIT) && !uart_busy;
    timeout_err_d = timeout_err_q || expire;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a baud-tick-gated UART driver model (divisor 16).
module tb_uart_tx_feeder;
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_feeder_if hif();
  uart_tx_feeder_if tif();

  logic       flush, uart_start, uart_busy, fifo_empty, frame_done, timeout_err;
  logic [8:0] uart_data;
  logic [4:0] fifo_count;
  logic       t_flush, t_busy, t_start, t_empty, t_done, t_err;
  logic [8:0] t_data;
  logic [4:0] t_count;

  uart_tx_feeder #(.DEPTH(16), .START_TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .wr_if(hif), .flush(flush),
    .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  uart_tx_feeder #(.DEPTH(16), .START_TIMEOUT(64)) dut_to (
    .clk(clk), .rst(rst), .wr_if(tif), .flush(t_flush),
    .uart_start(t_start), .uart_data(t_data), .uart_busy(t_busy),
    .fifo_count(t_count), .fifo_empty(t_empty),
    .frame_done(t_done), .timeout_err(t_err)
  );

  // Driver model: samples start on a baud tick, stays busy for 10 ticks
  logic       drv_en, drv_busy, man_mode, man_busy;
  logic [3:0] baud_cnt, bit_cnt;
  logic [8:0] cap_mem [0:63];
  int         cap_n = 0;
  int         fd_n  = 0;

  assign uart_busy = man_mode ? man_busy : drv_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      drv_busy <= 1'b0;
    end else begin
      baud_cnt <= baud_cnt + 4'd1;
      if (baud_cnt == 4'd15) begin
        if (!drv_busy) begin
          if (drv_en && uart_start) begin
            drv_busy         <= 1'b1;
            bit_cnt          <= '0;
            cap_mem[cap_n]   <= uart_data;
            cap_n            <= cap_n + 1;
            $display("frame start data=0x%03h", uart_data);
          end
        end else if (bit_cnt == 4'd9) begin
          drv_busy <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  always @(posedge clk) if (frame_done) fd_n <= fd_n + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [8:0] d);
    hif.wr_valid = 1'b1;
    hif.wr_data  = d;
    @(negedge clk);
    hif.wr_valid = 1'b0;
    $display("write 0x%03h count=%0d", d, fifo_count);
  endtask

  typedef struct {
    logic [8:0] data;
    logic       exp_ready;
    logic [4:0] exp_count;
  } vec_t;
  vec_t vecs [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cap_base, fd_base;
    logic bad;

    for (int i = 0; i < 16; i++) begin
      vecs[i].data      = 9'h100 + 9'(i);
      vecs[i].exp_ready = 1'b1;
      vecs[i].exp_count = 5'(i + 1);
    end
    vecs[16].data      = 9'h1EE;
    vecs[16].exp_ready = 1'b0;
    vecs[16].exp_count = 5'd16;

    rst = 1'b1; flush = 1'b0; t_flush = 1'b0; t_busy = 1'b0;
    hif.wr_valid = 1'b0; hif.wr_data = '0; tif.wr_valid = 1'b0; tif.wr_data = '0;
    drv_en = 1'b1; man_mode = 1'b0; man_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", uart_start, 0);
    chk("rst_ready", hif.wr_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_done", frame_done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_t_err", t_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Timeout: busy tied low, 64-cycle limit
    tif.wr_valid = 1'b1; tif.wr_data = 9'h055;
    @(negedge clk);
    tif.wr_valid = 1'b0;
    chk("to_count1", t_count, 1);
    chk("to_start_n1", t_start, 0);
    @(negedge clk);
    chk("to_start_n2", t_start, 1);
    repeat (63) @(negedge clk);
    chk("to_last_req_start", t_start, 1);
    chk("to_last_req_err", t_err, 0);
    @(negedge clk);
    chk("to_err_set", t_err, 1);
    chk("to_start_drop", t_start, 0);
    chk("to_count_kept", t_count, 1);
    chk("to_data_kept", t_data, 9'h055);
    @(negedge clk);
    chk("to_retry_start", t_start, 1);
    $display("timeout transaction err=%0b", t_err);

    // Single word
    fd_base = fd_n; cap_base = cap_n;
    hif.wr_valid = 1'b1; hif.wr_data = 9'h0A5;
    @(negedge clk);
    hif.wr_valid = 1'b0;
    chk("sw_count1", fifo_count, 1);
    chk("sw_start_n1", uart_start, 0);
    @(negedge clk);
    chk("sw_start_n2", uart_start, 1);
    n = 0; bad = 1'b0;
    while (!uart_busy && n < 40) begin
      if (uart_start !== 1'b1 || uart_data !== 9'h0A5) bad = 1'b1;
      @(negedge clk); n++;
    end
    chk("sw_hold", bad, 0);
    chk("sw_busy_seen", uart_busy, 1);
    chk("sw_start_at_busy", uart_start, 1);
    @(negedge clk);
    chk("sw_start_off", uart_start, 0);
    chk("sw_count0", fifo_count, 0);
    n = 0;
    while (fd_n < fd_base + 1 && n < 400) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("sw_frames", fd_n - fd_base, 1);
    chk("sw_data", cap_mem[cap_base], 9'h0A5);

    // Burst into a stalled driver, from the vector table
    drv_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      hif.wr_valid = 1'b1; hif.wr_data = vecs[i].data;
      chk($sformatf("burst_ready_%0d", i), hif.wr_ready, vecs[i].exp_ready);
      @(negedge clk);
      chk($sformatf("burst_count_%0d", i), fifo_count, vecs[i].exp_count);
      $display("burst write 0x%03h ready=%0b count=%0d", vecs[i].data, hif.wr_ready, fifo_count);
    end
    hif.wr_valid = 1'b0;
    fd_base = fd_n; cap_base = cap_n;
    drv_en = 1'b1;
    n = 0;
    while (fifo_count == 5'd16 && n < 100) begin @(negedge clk); n++; end
    chk("burst_first_pop", fifo_count, 15);
    chk("burst_ready_back", hif.wr_ready, 1);
    n = 0;
    while (fd_n < fd_base + 16 && n < 5000) begin @(negedge clk); n++; end
    chk("burst_frames", fd_n - fd_base, 16);
    chk("burst_empty", fifo_empty, 1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("burst_order_%0d", k), cap_mem[cap_base + k], vecs[k].data);

    // Write coincident with pop at count 5
    repeat (3) @(negedge clk);
    drv_en = 1'b0; man_mode = 1'b1; man_busy = 1'b0;
    fd_base = fd_n;
    for (int i = 0; i < 5; i++) write_word(9'h020 + 9'(i));
    @(negedge clk);
    chk("pw_count_pre", fifo_count, 5);
    chk("pw_start", uart_start, 1);
    chk("pw_head", uart_data, 9'h020);
    man_busy = 1'b1;
    hif.wr_valid = 1'b1; hif.wr_data = 9'h025;
    @(negedge clk);
    hif.wr_valid = 1'b0;
    chk("pw_count_same", fifo_count, 5);
    chk("pw_start_off", uart_start, 0);
    chk("pw_new_head", uart_data, 9'h021);
    man_busy = 1'b0;
    @(negedge clk);
    chk("pw_frame_done", frame_done, 1);
    man_mode = 1'b0; drv_en = 1'b1;
    cap_base = cap_n;
    n = 0;
    while (fd_n < fd_base + 6 && n < 2500) begin @(negedge clk); n++; end
    chk("pw_frames", fd_n - fd_base, 6);
    for (int k = 0; k < 5; k++)
      chk($sformatf("pw_order_%0d", k), cap_mem[cap_base + k], 9'h021 + 9'(k));

    // Flush while a frame is in flight
    repeat (3) @(negedge clk);
    fd_base = fd_n; cap_base = cap_n;
    for (int i = 0; i < 4; i++) write_word(9'h031 + 9'(i));
    n = 0;
    while (!(uart_busy && !uart_start) && n < 100) begin @(negedge clk); n++; end
    chk("fl_in_wait", uart_busy && !uart_start, 1);
    chk("fl_count_pre", fifo_count, 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_count0", fifo_count, 0);
    chk("fl_empty", fifo_empty, 1);
    n = 0;
    while (fd_n < fd_base + 1 && n < 400) begin @(negedge clk); n++; end
    chk("fl_frame_done", fd_n - fd_base, 1);
    bad = 1'b0;
    repeat (200) begin
      if (uart_start !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("fl_no_restart", bad, 0);
    chk("fl_frames_sent", cap_n - cap_base, 1);
    chk("fl_data", cap_mem[cap_base], 9'h031);

    // Asynchronous reset while requesting
    drv_en = 1'b0;
    for (int i = 0; i < 4; i++) write_word(9'h041 + 9'(i));
    n = 0;
    while (!uart_start && n < 20) begin @(negedge clk); n++; end
    chk("rs_in_req", uart_start, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_start_async", uart_start, 0);
    chk("rs_count_async", fifo_count, 0);
    chk("rs_empty_async", fifo_empty, 1);
    chk("rs_ready_async", hif.wr_ready, 1);
    chk("rs_err_async", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    drv_en = 1'b1;
    @(negedge clk);
    fd_base = fd_n; cap_base = cap_n;
    write_word(9'h1FF);
    n = 0;
    while (fd_n < fd_base + 1 && n < 400) begin @(negedge clk); n++; end
    chk("rs_frames", fd_n - fd_base, 1);
    chk("rs_data", cap_mem[cap_base], 9'h1FF);
    chk("rs_count_end", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
